// File: rtl/fp_addsub_align_if.sv
// Handshake and data bundle for the FP add/sub operand-align stage.
// slave = the align block itself, master = upstream producer / downstream consumer.
interface fp_addsub_align_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        sign1;
  logic        sign2;
  logic [47:0] mantissa_sum;
  logic        carry;
  logic [7:0]  exp_res;
  logic        zero;
  logic        sticky_bit;
  logic        is_nan;
  logic        is_inf;

  modport master (
    output in_valid, op_a, op_b, op_sub, flush, out_ready,
    input  in_ready, out_valid, sign1, sign2, mantissa_sum, carry,
           exp_res, zero, sticky_bit, is_nan, is_inf
  );

  modport slave (
    input  in_valid, op_a, op_b, op_sub, flush, out_ready,
    output in_ready, out_valid, sign1, sign2, mantissa_sum, carry,
           exp_res, zero, sticky_bit, is_nan, is_inf
  );
endinterface

// File: rtl/fp_addsub_align.sv
// FP add/sub front end: unpack/compare/swap (stage 1), align + 48-bit magnitude
// add/sub with sticky (stage 2). Two-entry valid/ready pipeline with flush.
module fp_addsub_align (
  input  logic                clk,
  input  logic                reset_n,
  fp_addsub_align_if.slave    bus
);

  // Stage 1 registers
  logic        s1_valid;
  logic        s1_sign1;
  logic        s1_sign2;
  logic [23:0] s1_mant_lg;
  logic [23:0] s1_mant_sm;
  logic [7:0]  s1_diff;
  logic [7:0]  s1_exp;
  logic        s1_zero;
  logic        s1_nan;
  logic        s1_inf;

  logic s2_advance;
  logic accept;

  assign s2_advance  = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = ~s1_valid | s2_advance;
  assign accept      = bus.in_valid & bus.in_ready;

  // Unpack and swap
  logic [7:0]  exp_a, exp_b, eexp_a, eexp_b;
  logic [23:0] mant_a, mant_b;
  logic        sgn_a, sgn_b, a_is_lg;
  logic        zero_c, nan_c, inf_c;
  logic        sign1_c, sign2_c;
  logic [23:0] mant_lg_c, mant_sm_c;
  logic [7:0]  diff_c, exp_c;

  always_comb begin
    exp_a  = bus.op_a[30:23];
    exp_b  = bus.op_b[30:23];
    mant_a = {|exp_a, bus.op_a[22:0]};
    mant_b = {|exp_b, bus.op_b[22:0]};
    eexp_a = (exp_a == 8'd0) ? 8'd1 : exp_a;
    eexp_b = (exp_b == 8'd0) ? 8'd1 : exp_b;
    sgn_a  = bus.op_a[31];
    sgn_b  = bus.op_b[31] ^ bus.op_sub;
    a_is_lg = {eexp_a, mant_a} >= {eexp_b, mant_b};

    sign1_c   = sgn_b;
    sign2_c   = sgn_a;
    mant_lg_c = mant_b;
    mant_sm_c = mant_a;
    diff_c    = eexp_b - eexp_a;
    exp_c     = exp_b;
    if (a_is_lg) begin
      sign1_c   = sgn_a;
      sign2_c   = sgn_b;
      mant_lg_c = mant_a;
      mant_sm_c = mant_b;
      diff_c    = eexp_a - eexp_b;
      exp_c     = exp_a;
    end

    zero_c = (bus.op_a[30:0] == 31'd0) | (bus.op_b[30:0] == 31'd0);
    nan_c  = ((exp_a == 8'hFF) & (bus.op_a[22:0] != 23'd0)) |
             ((exp_b == 8'hFF) & (bus.op_b[22:0] != 23'd0));
    inf_c  = ((exp_a == 8'hFF) & (bus.op_a[22:0] == 23'd0)) |
             ((exp_b == 8'hFF) & (bus.op_b[22:0] == 23'd0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_sign1   <= 1'b0;
      s1_sign2   <= 1'b0;
      s1_mant_lg <= '0;
      s1_mant_sm <= '0;
      s1_diff    <= '0;
      s1_exp     <= '0;
      s1_zero    <= 1'b0;
      s1_nan     <= 1'b0;
      s1_inf     <= 1'b0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (accept) begin
        s1_sign1   <= sign1_c;
        s1_sign2   <= sign2_c;
        s1_mant_lg <= mant_lg_c;
        s1_mant_sm <= mant_sm_c;
        s1_diff    <= diff_c;
        s1_exp     <= exp_c;
        s1_zero    <= zero_c;
        s1_nan     <= nan_c;
        s1_inf     <= inf_c;
      end
    end
  end

  // Align and add/subtract
  logic [47:0] mant_big, mant_ext, mant_al, shift_mask;
  logic        sticky_c;
  logic [48:0] add_res;
  logic [47:0] sub_res;
  logic [47:0] sum_c;
  logic        carry_c;

  always_comb begin
    mant_big   = {s1_mant_lg, 24'd0};
    mant_ext   = {s1_mant_sm, 24'd0};
    shift_mask = '0;
    if (s1_diff >= 8'd48) begin
      mant_al  = '0;
      sticky_c = |s1_mant_sm;
    end else begin
      mant_al    = mant_ext >> s1_diff;
      shift_mask = (48'd1 << s1_diff) - 48'd1;
      sticky_c   = |(mant_ext & shift_mask);
    end
    add_res = {1'b0, mant_big} + {1'b0, mant_al};
    // Borrowing the sticky makes the difference the floor of the exact result
    sub_res = mant_big - mant_al - {47'd0, sticky_c};
    if (s1_sign1 == s1_sign2) begin
      sum_c   = add_res[47:0];
      carry_c = add_res[48];
    end else begin
      sum_c   = sub_res;
      carry_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid    <= 1'b0;
      bus.sign1        <= 1'b0;
      bus.sign2        <= 1'b0;
      bus.mantissa_sum <= '0;
      bus.carry        <= 1'b0;
      bus.exp_res      <= '0;
      bus.zero         <= 1'b0;
      bus.sticky_bit   <= 1'b0;
      bus.is_nan       <= 1'b0;
      bus.is_inf       <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (s2_advance) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.sign1        <= s1_sign1;
        bus.sign2        <= s1_sign2;
        bus.mantissa_sum <= sum_c;
        bus.carry        <= carry_c;
        bus.exp_res      <= s1_exp;
        bus.zero         <= s1_zero;
        bus.sticky_bit   <= sticky_c;
        bus.is_nan       <= s1_nan;
        bus.is_inf       <= s1_inf;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_align.sv
// Scoreboard bench for fp_addsub_align: directed vectors with hand-computed results.
module tb_fp_addsub_align;

  typedef struct packed {
    logic        s1;
    logic        s2;
    logic        c;
    logic [47:0] sum;
    logic [7:0]  e;
    logic        z;
    logic        st;
    logic        nan;
    logic        inf;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
    bit   lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    res_t        r;
  } vec_t;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  int   cyc;
  exp_t sb[$];
  vec_t vecs[11];

  fp_addsub_align_if bus ();

  fp_addsub_align dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t mk(input logic s1, input logic s2, input logic c,
                              input logic [47:0] sum, input logic [7:0] e,
                              input logic z, input logic st, input logic nan,
                              input logic inf);
    res_t r;
    r = {s1, s2, c, sum, e, z, st, nan, inf};
    return r;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r = {bus.sign1, bus.sign2, bus.carry, bus.mantissa_sum, bus.exp_res,
         bus.zero, bus.sticky_bit, bus.is_nan, bus.is_inf};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Scoreboard monitor: compares on every output transfer
  always @(negedge clk) begin
    res_t got;
    exp_t e;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      got = dut_res();
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got %h expected none", got);
      end else begin
        e = sb.pop_front();
        if (got !== e.r) begin
          fails++;
          $display("FAIL result: got %h expected %h", got, e.r);
        end
        if (e.lat) begin
          tests++;
          if (cyc - e.acc != 2) begin
            fails++;
            $display("FAIL latency: got %0d expected 2", cyc - e.acc);
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input vec_t v, input bit lat);
    exp_t e;
    bit   done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.op_a     = v.a;
    bus.op_b     = v.b;
    bus.op_sub   = v.sub;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.r   = v.r;
        e.acc = cyc;
        e.lat = lat;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    res_t snap;
    vec_t drop_v;
    tests = 0;
    fails = 0;
    cyc   = 0;
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, mk(0,0,1,48'h000000000000,8'h7F,0,0,0,0)};
    vecs[1]  = '{32'h3F800000, 32'h40000000, 1'b1, mk(1,0,0,48'h400000000000,8'h80,0,0,0,0)};
    vecs[2]  = '{32'h3F800000, 32'h21800000, 1'b0, mk(0,0,0,48'h800000000000,8'h7F,0,1,0,0)};
    vecs[3]  = '{32'h3F800000, 32'hA1800000, 1'b0, mk(0,1,0,48'h7FFFFFFFFFFF,8'h7F,0,1,0,0)};
    vecs[4]  = '{32'h00000001, 32'h00000001, 1'b0, mk(0,0,0,48'h000002000000,8'h00,0,0,0,0)};
    vecs[5]  = '{32'h3F800000, 32'h80000000, 1'b0, mk(0,1,0,48'h800000000000,8'h7F,1,0,0,0)};
    vecs[6]  = '{32'h7F800000, 32'h3F800000, 1'b0, mk(0,0,0,48'h800000000000,8'hFF,0,1,0,1)};
    vecs[7]  = '{32'h7FC00000, 32'h7FC00000, 1'b1, mk(0,1,0,48'h000000000000,8'hFF,0,0,1,0)};
    vecs[8]  = '{32'h3F800000, 32'h2B800001, 1'b1, mk(0,1,0,48'h7FFFFFFFFF7F,8'h7F,0,1,0,0)};
    vecs[9]  = '{32'h3F800000, 32'h28000000, 1'b0, mk(0,0,0,48'h800000000001,8'h7F,0,0,0,0)};
    vecs[10] = '{32'h3F800000, 32'h27800000, 1'b0, mk(0,0,0,48'h800000000000,8'h7F,0,1,0,0)};

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sub    = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_data", 64'(dut_res()), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back directed vectors, unstalled
    foreach (vecs[i]) send(vecs[i], 1'b1);
    wait_empty();

    // Backpressure: two accepted, third refused, outputs held
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(vecs[0], 1'b0);
    send(vecs[1], 1'b0);
    bus.in_valid = 1'b1;
    bus.op_a     = vecs[2].a;
    bus.op_b     = vecs[2].b;
    bus.op_sub   = vecs[2].sub;
    @(negedge clk);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    snap = dut_res();
    repeat (2) @(negedge clk);
    check("bp_in_ready_held", 64'(bus.in_ready), 64'd0);
    check("bp_stable", 64'(dut_res()), 64'(snap));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    fork
      send(vecs[2], 1'b0);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_no_gap", 64'(bus.out_valid), 64'd1);
        end
      end
    join
    wait_empty();

    // Flush with two entries in flight
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(vecs[3], 1'b0);
    send(vecs[4], 1'b0);
    bus.flush = 1'b1;
    @(posedge clk);
    sb.delete();
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;

    // Accept offered in the flush cycle is dropped
    drop_v = vecs[5];
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.op_a     = drop_v.a;
    bus.op_b     = drop_v.b;
    bus.op_sub   = drop_v.sub;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_drop", 64'(bus.out_valid), 64'd0);
    end

    // Asynchronous reset mid-stream
    @(posedge clk);
    #1;
    send(vecs[6], 1'b0);
    send(vecs[7], 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(vecs[8], 1'b1);
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
